modulation_bit_mapper: RTL

Upstream stage of the modulation pipe that produces the reference-level pair consumed by the V_2 else-branch delay stage. On `start` it latches a 32-bit data word and a baseline level, then walks the word MSB-first. For each bit it emits a symmetric level pair, `zero ± AMP`, held for `SPB` cycles. A `start`/`busy`/`valid` handshake matches the rest of the pipe.

---
 rtl/modulation_bit_mapper.sv | 93 +++++++++
 1 files changed

// File: rtl/modulation_bit_mapper.sv
// modulation_bit_mapper: serialises a latched word MSB-first into symmetric level pairs zero +/- AMP
//   clk                : rising-edge pipe clock
//   reset              : asynchronous active-low reset
//   start              : transmit request, honoured only in IDLE
//   input_bit, zero    : data word and baseline level, latched on accepted start
//   array_ref_wire_2   : registered in-phase level, base + s
//   array_ref_m_wire_2 : registered mirrored level, base - s
//   sample_valid       : level pair is a live sample
//   busy               : word in flight (first through last sample)
//   valid              : one-cycle word-complete pulse
module modulation_bit_mapper #(
  parameter int          NBITS = 32,
  parameter int          SPB   = 4,
  parameter logic [31:0] AMP   = 32'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] input_bit,
  input  logic [31:0] zero,
  output logic [31:0] array_ref_wire_2,
  output logic [31:0] array_ref_m_wire_2,
  output logic        sample_valid,
  output logic        busy,
  output logic        valid
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [4:0] IDX_TOP  = 5'(NBITS - 1);
  localparam logic [7:0] SPB_LAST = 8'(SPB - 1);
  state_t      state_q, state_d;
  logic [31:0] word_q, word_d, base_q, base_d, ref_q, ref_d, ref_m_q, ref_m_d, s;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  spb_cnt_q, spb_cnt_d;
  logic        sv_q, sv_d, valid_q, valid_d, last;
  assign last = spb_cnt_q == SPB_LAST;
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    base_d    = base_q;
    bit_idx_d = bit_idx_q;
    spb_cnt_d = spb_cnt_q;
    s         = word_q[bit_idx_q] ? AMP : ~AMP + 32'd1;
    // the level registers lag the state by one edge, so RUN state produces the next live sample
    sv_d      = state_q == RUN;
    valid_d   = state_q == DONE;
    ref_d     = sv_d ? base_q + s : base_q;
    ref_m_d   = sv_d ? base_q - s : base_q;
    case (state_q)
      IDLE: if (start) begin
        word_d    = input_bit;
        base_d    = zero;
        bit_idx_d = IDX_TOP;
        spb_cnt_d = 8'd0;
        state_d   = RUN;
      end
      RUN: begin
        spb_cnt_d = last ? 8'd0 : spb_cnt_q + 8'd1;
        bit_idx_d = last ? bit_idx_q - 5'd1 : bit_idx_q;
        state_d   = (last && bit_idx_q == 5'd0) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      base_q    <= '0;
      bit_idx_q <= '0;
      spb_cnt_q <= '0;
      ref_q     <= '0;
      ref_m_q   <= '0;
      sv_q      <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      base_q    <= base_d;
      bit_idx_q <= bit_idx_d;
      spb_cnt_q <= spb_cnt_d;
      ref_q     <= ref_d;
      ref_m_q   <= ref_m_d;
      sv_q      <= sv_d;
      valid_q   <= valid_d;
    end
  end
  assign array_ref_wire_2   = ref_q;
  assign array_ref_m_wire_2 = ref_m_q;
  assign sample_valid       = sv_q;
  // busy spans exactly the live samples
  assign busy               = sv_q;
  assign valid              = valid_q;
endmodule
